// File: rtl/proc_pkg.sv
// Shared processor-control definitions: word width, opcode map, fetch FSM states, time steps.
package proc_pkg;

  localparam int unsigned IW = 10;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_SLT  = 4'b0010;
  localparam logic [3:0] OP_SLL  = 4'b0011;
  localparam logic [3:0] OP_SLR  = 4'b0100;
  localparam logic [3:0] OP_ENDI = 4'b0101;
  localparam logic [3:0] OP_MV   = 4'b0110;
  localparam logic [3:0] OP_MVI  = 4'b0111;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StFetch = 2'b01,
    StImm   = 2'b10,
    StExec  = 2'b11
  } state_e;

  localparam logic [2:0] T0 = 3'b000;
  localparam logic [2:0] T1 = 3'b001;
  localparam logic [2:0] T2 = 3'b010;
  localparam logic [2:0] T3 = 3'b011;

  // Codes 1000-1111 are unassigned.
  function automatic logic is_illegal(logic [3:0] op);
    return op[3];
  endfunction

endpackage

// File: rtl/dec3to8.sv
// 3-to-8 one-hot decoder used for the X and Y register selects.
module dec3to8 (
  input  logic [2:0] sel,
  output logic [7:0] onehot
);

  always_comb begin
    onehot = 8'b0000_0001 << sel;
  end

endmodule

// File: rtl/fetch_step_unit.sv
// Instruction fetch and time-step sequencer feeding the control unit.
// Optional build macro FETCH_ILLEGAL_TRAP_EN: illegal opcodes set Err instead of acting as NOPs.
module fetch_step_unit #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned IW     = proc_pkg::IW
) (
  input  logic              clock,
  input  logic              Reset,
  input  logic              Run,
  input  logic              Done,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ready,
  input  logic [IW-1:0]     mem_rdata,
  output logic [IW-1:0]     IR,
  output logic [3:0]        Opcode,
  output logic [7:0]        Xreg,
  output logic [7:0]        Yreg,
  output logic [IW-1:0]     DIN,
  output logic [2:0]        Tstep,
  output logic              Busy,
  output logic              Err
);

  import proc_pkg::state_e;
  import proc_pkg::StIdle;
  import proc_pkg::StFetch;
  import proc_pkg::StImm;
  import proc_pkg::StExec;
  import proc_pkg::OP_MVI;
  import proc_pkg::T0;
  import proc_pkg::T1;
  import proc_pkg::T3;
  import proc_pkg::is_illegal;

  state_e            state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_inc;
  logic [3:0]        rdata_op;

  assign pc_inc   = pc + ADDR_W'(1);
  assign rdata_op = mem_rdata[IW-1:IW-4];
  assign Opcode   = IR[IW-1:IW-4];

  dec3to8 u_dec_x (
    .sel    (IR[5:3]),
    .onehot (Xreg)
  );

  dec3to8 u_dec_y (
    .sel    (IR[2:0]),
    .onehot (Yreg)
  );

  always_ff @(posedge clock) begin
    if (Reset) begin
      state    <= StIdle;
      pc       <= '0;
      mem_req  <= 1'b0;
      mem_addr <= '0;
      IR       <= '0;
      DIN      <= '0;
      Tstep    <= T0;
      Busy     <= 1'b0;
      Err      <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          if (Run && !Err) begin
            state    <= StFetch;
            mem_req  <= 1'b1;
            mem_addr <= pc;
            Busy     <= 1'b1;
          end
        end

        StFetch: begin
          if (mem_ready) begin
            IR <= mem_rdata;
            pc <= pc_inc;
            if (rdata_op == OP_MVI) begin
              // Request stays up; only the address moves on to the immediate word.
              state    <= StImm;
              mem_addr <= pc_inc;
            end else if (is_illegal(rdata_op)) begin
`ifdef FETCH_ILLEGAL_TRAP_EN
              state   <= StIdle;
              mem_req <= 1'b0;
              Busy    <= 1'b0;
              Err     <= 1'b1;
`else
              if (Run) begin
                mem_addr <= pc_inc;
              end else begin
                state   <= StIdle;
                mem_req <= 1'b0;
                Busy    <= 1'b0;
              end
`endif
            end else begin
              state   <= StExec;
              mem_req <= 1'b0;
              Tstep   <= T1;
            end
          end
        end

        StImm: begin
          if (mem_ready) begin
            DIN     <= mem_rdata;
            pc      <= pc_inc;
            mem_req <= 1'b0;
            state   <= StExec;
            Tstep   <= T1;
          end
        end

        StExec: begin
          if (Done) begin
            Tstep <= T0;
            if (Run) begin
              state    <= StFetch;
              mem_req  <= 1'b1;
              mem_addr <= pc;
            end else begin
              state <= StIdle;
              Busy  <= 1'b0;
            end
          end else if (Tstep == T3) begin
            // Control unit never finished the instruction.
            Err   <= 1'b1;
            Tstep <= T0;
            state <= StIdle;
            Busy  <= 1'b0;
          end else begin
            Tstep <= Tstep + 3'd1;
          end
        end

        default: state <= StIdle;
      endcase
    end
  end

endmodule
